demux4_buffered: RTL and testbench
==================================

// Module: demux4_buffered
// PURPOSE
//   Inverse of the datapath select muxes: steers one incoming word to one of four
//   destinations chosen by a 2-bit select, using a valid/ready handshake.
//   Each destination has its own 2-entry FIFO, so a stalled consumer blocks only
//   its own channel. Sits between the writeback/result producer and the four
//   consumers (regfile port, dmem store path, IO port, debug tap).
// PARAMETERS
//   WIDTH   8   data word width in bits; WIDTH >= 1
// PORTS
//   clk        in   1          single clock; all state on rising edge
//   rst        in   1          asynchronous, active-high reset
//   in_valid   in   1          input word present
//   in_ready   out  1          input accepted this cycle when in_valid && in_ready
//   in_sel     in   2          destination channel 0..3
//   in_data    in   WIDTH      input word
//   out_valid  out  4          bit i: channel i FIFO head valid
//   out_ready  in   4          bit i: channel i consumer takes head this cycle
//   out_data   out  4*WIDTH    channel i head at [i*WIDTH +: WIDTH]
//   idle       out  1          all four FIFOs empty
// BEHAVIOUR
//   - Reset: asynchronous, active-high; clk and rst are the only clock and reset.
//     While rst=1: all FIFOs empty, out_valid=4'b0, out_data=0, idle=1,
//     in_ready=1. Reset mid-transfer discards all stored words without delivering them.
//   - in_ready = !full[in_sel], the selected FIFO has fewer than 2 entries.
//     in_ready depends only on FIFO state and in_sel, never on out_ready.
//     This gives no combinational ready path from output to input.
//   - Push: when in_valid && in_ready, in_data is written to FIFO[in_sel] at the edge.
//     Unselected channels are never written.
//   - Latency: a word pushed into an empty FIFO appears on out_valid/out_data the
//     next cycle. There is no same-cycle bypass.
//   - Pop: when out_valid[i] && out_ready[i], the head is removed at the edge.
//     The second entry, if present, becomes the head on the next cycle.
//   - Stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] holds constant.
//   - Simultaneous push and pop on the same channel with count=1: count stays 1 and
//     the new word becomes the head. With count=2, in_ready=0, so no push occurs.
//   - out_ready[i] while out_valid[i]=0 is ignored, with no underflow.
//   - Order is preserved within each channel. No ordering is defined across channels.
//   - in_valid=1 while in_ready=0: the word is not taken. The producer holds
//     in_data/in_sel until accepted. The block does not check this.
//   - Per-channel count is in 0..2. Read and write pointers are 1-bit and wrap 1->0.
//   - out_data of an empty channel is don't-care after reset. The bench checks data
//     only when valid.
//   - idle = &(count==0) over all channels.
// STRUCTURE
//   - Shared package: localparams N_CH=4, SEL_W=2, FIFO_DEPTH=2.
//   - One sub-module, fifo2 #(WIDTH):
//     ports clk, rst, push, din, full, pop, dout, valid, empty.
//   - Four instances via generate. The top level holds only the select decode and
//     the ready mux.
//   - Target size: about 150-200 lines total.
// TESTING
//   1. Reset then idle: rst pulse mid-cycle -> out_valid=0000, idle=1, in_ready=1,
//      asynchronously, with no clock edge needed.
//   2. Single route: in_sel=2, in_data=8'hA5, one cycle -> next cycle
//      out_valid=0100, ch2 data=A5. out_ready[2]=1 -> out_valid=0000, idle=1.
//   3. Backpressure: out_ready=0000, push 8'h11 then 8'h22 to ch1 -> in_ready=0
//      for sel=1 and 1 for sel=0. Release out_ready[1] -> pops 11 then 22, in order.
//   4. Isolation: ch3 full and stalled, stream 8'h01..8'h08 alternating to ch0/ch2
//      with ready=1 -> all eight delivered in order per channel, ch3 unchanged.
//   5. Concurrent push/pop: ch0 count=1 (head 8'h10), push 8'h20 with out_ready[0]=1
//      -> count stays 1, head=20 next cycle.
//   6. Reset mid-operation: two channels holding data, assert rst -> all out_valid
//      drop at once. Post-reset push 8'h7E to ch1 -> only 7E seen on ch1.

Source files
------------

// File: rtl/demux4_buffered_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 demultiplexer.
//   N_CH       number of destination channels
//   SEL_W      width of the channel select
//   FIFO_DEPTH entries per channel FIFO
//   CNT_W      width of a per-channel occupancy count (0..FIFO_DEPTH)
package demux4_buffered_pkg;

   localparam int unsigned N_CH       = 4;
   localparam int unsigned SEL_W      = 2;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

   // One-hot channel decode of a select value.
   function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      return N_CH'(1) << sel;
   endfunction

endpackage

// File: rtl/demux4_buffered_if.sv
// Handshake bundle for demux4_buffered.
//   in_valid/in_ready/in_sel/in_data : producer side, one word routed per handshake
//   out_valid/out_ready/out_data     : four consumer channels, channel i at bit i /
//                                      out_data[i*WIDTH +: WIDTH]
//   idle                             : all channel FIFOs empty
// master = producer/consumer environment, slave = the demux.
interface demux4_buffered_if #(
   parameter int unsigned WIDTH = 8
);
   import demux4_buffered_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        in_sel;
   logic [WIDTH-1:0]        in_data;
   logic [N_CH-1:0]         out_valid;
   logic [N_CH-1:0]         out_ready;
   logic [N_CH*WIDTH-1:0]   out_data;
   logic                    idle;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data, idle
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data, idle
   );

endinterface

// File: rtl/demux4_buffered_fifo2.sv
// Two-entry FIFO used for each demux channel.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write din when push and not full
//   full     : two entries stored
//   pop      : remove head when pop and valid (ignored while empty)
//   dout     : head entry, valid : head present, empty : no entries
module fifo2
   import demux4_buffered_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign valid   = !empty;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && valid;

   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q; // idle, or push+pop keeps occupancy
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/demux4_buffered.sv
// Buffered 1-to-4 demultiplexer: routes each accepted input word to the channel
// chosen by in_sel, each channel backed by its own 2-entry FIFO so a stalled
// consumer only blocks its own channel.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : demux4_buffered_if slave modport (input handshake, 4 output channels,
//              idle)
module demux4_buffered
   import demux4_buffered_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   demux4_buffered_if.slave  bus
);

   logic [N_CH-1:0]       full;
   logic [N_CH-1:0]       empty;
   logic [N_CH-1:0]       push;
   logic [N_CH-1:0]       head_valid;
   logic [N_CH*WIDTH-1:0] head_data;
   logic                  in_ready;

   // Ready depends only on FIFO state and select, never on out_ready.
   assign in_ready      = !full[bus.in_sel];
   assign push          = sel_onehot(bus.in_sel) & {N_CH{bus.in_valid && in_ready}};

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = head_valid;
   assign bus.out_data  = head_data;
   assign bus.idle      = &empty;

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      fifo2 #(
         .WIDTH (WIDTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[ch]),
         .din   (bus.in_data),
         .full  (full[ch]),
         .pop   (bus.out_ready[ch]),
         .dout  (head_data[ch*WIDTH +: WIDTH]),
         .valid (head_valid[ch]),
         .empty (empty[ch])
      );
   end

endmodule

// File: tb/tb_demux4_buffered.sv
module tb_demux4_buffered;

   logic clk;
   logic rst;
   int   checks;
   int   passes;
   int   fails;

   logic [7:0] sb [4][$];

   demux4_buffered_if #(.WIDTH(8)) bus ();

   demux4_buffered #(
      .WIDTH (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [1:0] sel, input logic [7:0] d,
                        input logic [3:0] rdy);
      bus.in_valid  = v;
      bus.in_sel    = sel;
      bus.in_data   = d;
      bus.out_ready = rdy;
   endtask

   // One clock cycle: check DUT against the scoreboard, then advance the model
   // with whatever handshakes happen at the coming edge.
   task automatic step(output bit acc);
      bit all_empty;
      #1;
      all_empty = 1'b1;
      for (int ch = 0; ch < 4; ch++) begin
         chk($sformatf("ch%0d_valid", ch), 32'(bus.out_valid[ch]), 32'(sb[ch].size() != 0));
         if (sb[ch].size() != 0) begin
            all_empty = 1'b0;
            chk($sformatf("ch%0d_data", ch), 32'(bus.out_data[ch*8 +: 8]), 32'(sb[ch][0]));
         end
      end
      chk("idle", 32'(bus.idle), 32'(all_empty));
      if (bus.in_valid) begin
         chk("in_ready", 32'(bus.in_ready), 32'(sb[bus.in_sel].size() < 2));
      end
      acc = bus.in_valid && bus.in_ready;
      for (int ch = 0; ch < 4; ch++) begin
         if (bus.out_ready[ch] && sb[ch].size() != 0) void'(sb[ch].pop_front());
      end
      if (acc) sb[bus.in_sel].push_back(bus.in_data);
      @(negedge clk);
   endtask

   task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic [3:0] rdy);
      bit acc;
      acc = 1'b0;
      drive(1'b1, sel, d, rdy);
      for (int n = 0; n < 8 && !acc; n++) step(acc);
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic idle_steps(input logic [3:0] rdy, input int n);
      bit acc;
      drive(1'b0, 2'd0, 8'h00, rdy);
      for (int k = 0; k < n; k++) step(acc);
   endtask

   initial begin
      checks = 0;
      passes = 0;
      fails  = 0;
      rst    = 1'b0;
      drive(1'b0, 2'd0, 8'h00, 4'b0000);

      // 1. asynchronous reset, no clock edge yet
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_idle", 32'(bus.idle), 32'h1);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      chk("rst_out_data", bus.out_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // 2. single route to ch2
      send(2'd2, 8'hA5, 4'b0000);
      chk("route_valid", 32'(bus.out_valid), 32'b0100);
      chk("route_data", 32'(bus.out_data[23:16]), 32'hA5);
      idle_steps(4'b0100, 1);
      chk("route_drained", 32'(bus.out_valid), 32'h0);
      chk("route_idle", 32'(bus.idle), 32'h1);

      // 3. backpressure on ch1
      send(2'd1, 8'h11, 4'b0000);
      send(2'd1, 8'h22, 4'b0000);
      drive(1'b1, 2'd1, 8'h33, 4'b0000);
      #1 chk("bp_ready_sel1", 32'(bus.in_ready), 32'h0);
      bus.in_sel = 2'd0;
      #1 chk("bp_ready_sel0", 32'(bus.in_ready), 32'h1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      idle_steps(4'b0010, 3);
      chk("bp_drained", 32'(bus.out_valid), 32'h0);

      // 4. isolation: ch3 full and stalled while ch0/ch2 stream
      send(2'd3, 8'h33, 4'b0000);
      send(2'd3, 8'h44, 4'b0000);
      for (int i = 1; i <= 8; i++) begin
         send((i % 2 == 1) ? 2'd0 : 2'd2, 8'(i), 4'b0101);
      end
      idle_steps(4'b0101, 2);
      chk("iso_valid", 32'(bus.out_valid), 32'b1000);
      chk("iso_ch3_head", 32'(bus.out_data[31:24]), 32'h33);
      drive(1'b0, 2'd3, 8'h00, 4'b0000);
      #1 chk("iso_ch3_full", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      idle_steps(4'b1000, 3);

      // 5. concurrent push/pop on ch0 with one entry
      send(2'd0, 8'h10, 4'b0000);
      send(2'd0, 8'h20, 4'b0001);
      chk("pp_valid", 32'(bus.out_valid), 32'b0001);
      chk("pp_head", 32'(bus.out_data[7:0]), 32'h20);
      drive(1'b0, 2'd0, 8'h00, 4'b0000);
      #1 chk("pp_count1", 32'(bus.in_ready), 32'h1);
      @(negedge clk);
      idle_steps(4'b0001, 2);

      // 6. reset mid-operation
      send(2'd0, 8'h55, 4'b0000);
      send(2'd2, 8'h66, 4'b0000);
      chk("pre_rst_valid", 32'(bus.out_valid), 32'b0101);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("mid_rst_idle", 32'(bus.idle), 32'h1);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
      for (int ch = 0; ch < 4; ch++) sb[ch].delete();
      @(negedge clk);
      rst = 1'b0;
      send(2'd1, 8'h7E, 4'b0000);
      chk("post_rst_valid", 32'(bus.out_valid), 32'b0010);
      chk("post_rst_data", 32'(bus.out_data[15:8]), 32'h7E);
      idle_steps(4'b1111, 2);
      chk("post_rst_idle", 32'(bus.idle), 32'h1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
